// File: rtl/accumulator_seg_pipe.sv
// rtl/accumulator_seg_pipe.sv - segmented, carry-pipelined accumulator with deskewed result
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   in_valid      operation present this cycle (always accepted)
//   op            00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
//   din           operand, sign- or zero-extended per SIGNED_ADD
//   out_valid     data holds the result of one accepted operation
//   data, msb     deskewed accumulator value and its top bit
//   ovf           unsigned wrap (ADD carry / SUB borrow) of this result
//   ovf_sticky    OR of ovf since the last LOAD, CLEAR or reset
module accumulator_seg_pipe #(
    parameter int ACC_WIDTH  = 32,
    parameter int SEG_WIDTH  = 8,
    parameter int ADD_WIDTH  = 8,
    parameter int SIGNED_ADD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [1:0]           op,
    input  logic [ADD_WIDTH-1:0] din,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] data,
    output logic                 msb,
    output logic                 ovf,
    output logic                 ovf_sticky
);

    localparam int NSEG = ACC_WIDTH / SEG_WIDTH;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;

    logic [ACC_WIDTH-1:0] x_ext;
    logic [ACC_WIDTH-1:0] x_mod;
    logic [NSEG-1:0]      stage_v;    // valid seen by segment i this cycle
    logic [2*NSEG-1:0]    stage_op;   // op seen by segment i this cycle
    logic [NSEG-1:0]      carry;      // registered carry-out of segment i

    logic       out_valid_q;
    logic [1:0] out_op_q;
    logic       sticky_q;

    generate
        if (SIGNED_ADD != 0) begin : g_sext
            assign x_ext = ACC_WIDTH'($signed(din));
        end else begin : g_zext
            assign x_ext = ACC_WIDTH'(din);
        end
    endgenerate

    // SUB inverts the operand up front; the +1 enters as segment 0's carry-in.
    assign x_mod = (op == OP_SUB) ? ~x_ext : x_ext;

    genvar i;
    generate
        for (i = 0; i < NSEG; i++) begin : g_seg
            localparam int DSK = NSEG - 1 - i;

            logic                 v;
            logic [1:0]           o;
            logic [SEG_WIDTH-1:0] xs;
            logic                 cin;
            logic [SEG_WIDTH-1:0] seg_q;
            logic                 c_q;
            logic [SEG_WIDTH:0]   seg_d;

            if (i == 0) begin : g_head
                assign v   = in_valid;
                assign o   = op;
                assign xs  = x_mod[SEG_WIDTH-1:0];
                assign cin = (op == OP_SUB);
            end else begin : g_skew
                logic                 v_q;
                logic [1:0]           o_q;
                logic [SEG_WIDTH-1:0] xd_q [i];

                // Segment i's control is segment i-1's control one cycle later;
                // its operand slice runs through its own i-deep delay line.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        v_q <= 1'b0;
                        o_q <= 2'b00;
                        for (int k = 0; k < i; k++) xd_q[k] <= '0;
                    end else begin
                        v_q     <= stage_v[i-1];
                        o_q     <= stage_op[2*(i-1) +: 2];
                        xd_q[0] <= x_mod[i*SEG_WIDTH +: SEG_WIDTH];
                        for (int k = 1; k < i; k++) xd_q[k] <= xd_q[k-1];
                    end
                end

                assign v   = v_q;
                assign o   = o_q;
                assign xs  = xd_q[i-1];
                assign cin = carry[i-1];
            end

            assign seg_d = {1'b0, seg_q} + {1'b0, xs} + {{SEG_WIDTH{1'b0}}, cin};

            // Bubbles, LOAD and CLEAR all zero the carry so the next segment
            // never adds a stale carry into an unrelated operation.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    seg_q <= '0;
                    c_q   <= 1'b0;
                end else if (!v) begin
                    c_q <= 1'b0;
                end else begin
                    case (o)
                        OP_ADD, OP_SUB: begin
                            seg_q <= seg_d[SEG_WIDTH-1:0];
                            c_q   <= seg_d[SEG_WIDTH];
                        end
                        OP_LOAD: begin
                            seg_q <= xs;
                            c_q   <= 1'b0;
                        end
                        default: begin
                            seg_q <= '0;
                            c_q   <= 1'b0;
                        end
                    endcase
                end
            end

            assign stage_v[i]          = v;
            assign stage_op[2*i +: 2]  = o;
            assign carry[i]            = c_q;

            // Lower segments finish earlier; delay them so all slices of data
            // belong to the same operation.
            if (DSK > 0) begin : g_dsk
                logic [SEG_WIDTH-1:0] dk_q [DSK];
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int k = 0; k < DSK; k++) dk_q[k] <= '0;
                    end else begin
                        dk_q[0] <= seg_q;
                        for (int k = 1; k < DSK; k++) dk_q[k] <= dk_q[k-1];
                    end
                end
                assign data[i*SEG_WIDTH +: SEG_WIDTH] = dk_q[DSK-1];
            end else begin : g_nodsk
                assign data[i*SEG_WIDTH +: SEG_WIDTH] = seg_q;
            end
        end
    endgenerate

    // Top segment updates on the same edge as these, so carry[NSEG-1] is the
    // top carry-out of the result currently on data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_op_q    <= 2'b00;
            sticky_q    <= 1'b0;
        end else begin
            out_valid_q <= stage_v[NSEG-1];
            out_op_q    <= stage_op[2*(NSEG-1) +: 2];
            sticky_q    <= ovf_sticky;
        end
    end

    assign out_valid  = out_valid_q;
    assign msb        = data[ACC_WIDTH-1];
    assign ovf        = out_valid_q & (((out_op_q == OP_ADD) &  carry[NSEG-1]) |
                                       ((out_op_q == OP_SUB) & ~carry[NSEG-1]));
    // op[1] set means LOAD or CLEAR: the emerging result restarts the sticky flag.
    assign ovf_sticky = ~(out_valid_q & out_op_q[1]) & (sticky_q | ovf);

endmodule

// File: tb/tb_accumulator_seg_pipe.sv
// tb/tb_accumulator_seg_pipe.sv - scoreboard bench for accumulator_seg_pipe (unsigned and signed instances)
module tb_accumulator_seg_pipe;

    localparam int NSEG = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [7:0]  din = 8'h00;

    logic        ov_u, ov_s, msb_u, msb_s, ovf_u, ovf_s, stk_u, stk_s;
    logic [31:0] data_u, data_s;

    accumulator_seg_pipe #(.ACC_WIDTH(32), .SEG_WIDTH(8), .ADD_WIDTH(8), .SIGNED_ADD(0)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .din(din),
        .out_valid(ov_u), .data(data_u), .msb(msb_u), .ovf(ovf_u), .ovf_sticky(stk_u)
    );

    accumulator_seg_pipe #(.ACC_WIDTH(32), .SEG_WIDTH(8), .ADD_WIDTH(8), .SIGNED_ADD(1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .din(din),
        .out_valid(ov_s), .data(data_s), .msb(msb_s), .ovf(ovf_s), .ovf_sticky(stk_s)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        logic        stk;
        int unsigned cyc;
    } exp_t;

    exp_t q_u[$];
    exp_t q_s[$];

    logic [31:0] acc_u = '0, acc_s = '0;
    logic        mstk_u = 1'b0, mstk_s = 1'b0;
    logic [31:0] last_u = '0, last_s = '0;
    logic        lstk_u = 1'b0, lstk_s = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input bit sgn, input logic [1:0] o, input logic [7:0] d);
        logic [31:0] x, a;
        logic [32:0] full;
        logic        s;
        exp_t        e;
        x = sgn ? {{24{d[7]}}, d} : {24'h0, d};
        a = sgn ? acc_s : acc_u;
        s = sgn ? mstk_s : mstk_u;
        case (o)
            2'b00: begin full = {1'b0, a} + {1'b0, x}; e.data = full[31:0]; e.ovf = full[32]; end
            2'b01: begin e.data = a - x; e.ovf = (a < x); end
            2'b10: begin e.data = x; e.ovf = 1'b0; end
            default: begin e.data = '0; e.ovf = 1'b0; end
        endcase
        e.stk = o[1] ? 1'b0 : (s | e.ovf);
        e.cyc = cyc + NSEG;
        if (sgn) begin acc_s = e.data; mstk_s = e.stk; q_s.push_back(e); end
        else     begin acc_u = e.data; mstk_u = e.stk; q_u.push_back(e); end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [7:0] d);
        @(posedge clk); #1;
        in_valid = 1'b1; op = o; din = d;
        push_exp(1'b0, o, d);
        push_exp(1'b1, o, d);
    endtask

    task automatic bubble(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0; op = $urandom_range(3, 0); din = $urandom_range(255, 0);
        end
    endtask

    task automatic mon(input bit sgn, input logic v, input logic [31:0] dt, input logic m,
                       input logic ov, input logic st);
        exp_t  e;
        string p;
        p = sgn ? "s_" : "u_";
        if (v) begin
            if ((sgn ? q_s.size() : q_u.size()) == 0) begin
                check({p, "spurious_valid"}, 1, 0);
            end else begin
                if (sgn) e = q_s.pop_front(); else e = q_u.pop_front();
                check({p, "latency"}, 64'(cyc), 64'(e.cyc));
                check({p, "data"}, 64'(dt), 64'(e.data));
                check({p, "msb"}, 64'(m), 64'(e.data[31]));
                check({p, "ovf"}, 64'(ov), 64'(e.ovf));
                check({p, "sticky"}, 64'(st), 64'(e.stk));
                if (sgn) begin last_s = e.data; lstk_s = e.stk; end
                else     begin last_u = e.data; lstk_u = e.stk; end
            end
        end else begin
            check({p, "hold_data"}, 64'(dt), 64'(sgn ? last_s : last_u));
            check({p, "idle_ovf"}, 64'(ov), 0);
            check({p, "hold_sticky"}, 64'(st), 64'(sgn ? lstk_s : lstk_u));
        end
    endtask

    always @(negedge clk) begin
        mon(1'b0, ov_u, data_u, msb_u, ovf_u, stk_u);
        mon(1'b1, ov_s, data_s, msb_s, ovf_s, stk_s);
    end

    task automatic model_reset();
        q_u.delete(); q_s.delete();
        acc_u = '0; acc_s = '0; mstk_u = 1'b0; mstk_s = 1'b0;
        last_u = '0; last_s = '0; lstk_u = 1'b0; lstk_s = 1'b0;
    endtask

    initial begin
        // reset and idle: monitor checks data/sticky stay 0 and no valid appears
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_data_u", 64'(data_u), 0);
        check("reset_valid_s", 64'(ov_s), 0);
        bubble(10);

        // long carry run across the 0xFF -> 0x100 boundary
        do_op(2'b11, 8'h00);
        for (int k = 0; k < 256; k++) do_op(2'b00, 8'h01);
        bubble(6);
        check("run_final_u", 64'(data_u), 64'h100);

        // signed LOAD 0xFF, ADD 1 wraps, CLEAR drops sticky
        do_op(2'b10, 8'hFF);
        do_op(2'b00, 8'h01);
        do_op(2'b11, 8'h00);
        bubble(6);
        check("sext_cleared_s", 64'(data_s), 0);

        // borrow on SUB, carry on ADD
        do_op(2'b11, 8'h00);
        do_op(2'b01, 8'h01);
        do_op(2'b00, 8'h01);
        bubble(6);

        // interleaved CLEAR and bubble
        do_op(2'b00, 8'h05);
        do_op(2'b11, 8'h00);
        do_op(2'b00, 8'h03);
        bubble(1);
        do_op(2'b00, 8'hFE);
        bubble(6);
        check("mix_final_u", 64'(data_u), 64'h101);

        // random mix with occasional bubbles
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(4, 0) == 0) bubble(1);
            else do_op(2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)));
        end
        bubble(6);

        // asynchronous reset with ops in flight
        do_op(2'b00, 8'h11);
        do_op(2'b00, 8'h22);
        do_op(2'b00, 8'h33);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_data_u", 64'(data_u), 0);
        check("async_rst_data_s", 64'(data_s), 0);
        check("async_rst_valid_u", 64'(ov_u), 0);
        @(posedge clk); #1 rst = 1'b0;
        bubble(8);
        do_op(2'b00, 8'h07);
        bubble(6);
        check("post_rst_data_u", 64'(data_u), 64'h7);

        check("drain_u", 64'(q_u.size()), 0);
        check("drain_s", 64'(q_s.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
